// File: rtl/load_store_r_i_instruction.sv
// Single-cycle execute/memory/writeback datapath for lw, sw, R- and I-type ALU ops.
// Holds the register file, ALU, data memory and the writeback selectors.

module ALU_32 #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [3:0]   i_op,
    output logic [N-1:0] o_result,
    output logic         o_carry,
    output logic         o_overflow,
    output logic         o_slt
);
    logic         w_sub;
    logic         w_arith;
    logic [N-1:0] w_bop;
    logic [N-1:0] w_sum;
    logic         w_cout;
    logic         w_ovf;

    assign w_sub   = (i_op == 4'b0110);
    assign w_arith = w_sub || (i_op == 4'b0010);
    assign w_bop   = w_sub ? ~i_b : i_b;
    assign {w_cout, w_sum} = {1'b0, i_a} + {1'b0, w_bop} + (N+1)'(w_sub);
    assign w_ovf   = (i_a[N-1] == w_bop[N-1]) && (w_sum[N-1] != i_a[N-1]);
    assign o_slt   = $signed(i_a) < $signed(i_b);
    assign o_carry    = w_arith ? w_cout : 1'b0;
    assign o_overflow = w_arith ? w_ovf : 1'b0;

    // Operation select; undefined codes produce zero
    always_comb begin
        o_result = '0;
        case (i_op)
            4'b0000: o_result = i_a & i_b;
            4'b0001: o_result = i_a | i_b;
            4'b0010: o_result = w_sum;
            4'b0110: o_result = w_sum;
            4'b0111: o_result = {{(N-1){1'b0}}, o_slt};
            4'b1100: o_result = ~(i_a | i_b);
            default: o_result = '0;
        endcase
    end
endmodule

module Mux_2_1_32 #(
    parameter int N = 32
) (
    input  logic         i_sel,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_y
);
    assign o_y = i_sel ? i_b : i_a;
endmodule

module DataMemory #(
    parameter int N         = 32,
    parameter int MEM_WORDS = 256,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_addr,
    input  logic [N-1:0]  i_wdata,
    input  logic          i_we,
    input  logic          i_re,
    output logic [N-1:0]  o_rdata
);
    logic [N-1:0] r_mem [MEM_WORDS];

    assign o_rdata = i_re ? r_mem[i_addr] : '0;

    // Reset preloads words 1..10 with 8; otherwise commit stores
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++)
                r_mem[i] <= (i >= 1 && i <= 10) ? N'(8) : '0;
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end
endmodule

module load_store_r_i_instruction #(
    parameter int N         = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  instruction,
    input  logic [3:0]   ALU_OP,
    input  logic         RegWrite,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic         MemtoReg,
    input  logic         ALUSrc,
    input  logic         RegDst,
    output logic [N-1:0] alu_result,
    output logic [N-1:0] wb_data,
    output logic         zero,
    output logic         carry_out,
    output logic         overflow,
    output logic         slt
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [N-1:0] r_regs [32];
    logic [4:0]   w_rs;
    logic [4:0]   w_rt;
    logic [4:0]   w_rd;
    logic [4:0]   w_dest;
    logic [N-1:0] w_imm;
    logic [N-1:0] w_a;
    logic [N-1:0] w_rt_data;
    logic [N-1:0] w_b;
    logic [N-1:0] w_rdata;
    logic         w_unused;

    assign w_rs     = instruction[25:21];
    assign w_rt     = instruction[20:16];
    assign w_rd     = instruction[15:11];
    assign w_unused = ^instruction[31:26];
    assign w_imm    = {{(N-16){instruction[15]}}, instruction[15:0]};
    assign w_dest   = RegDst ? w_rd : w_rt;

    assign w_a      = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
    assign w_rt_data = (w_rt == 5'd0) ? '0 : r_regs[w_rt];

    Mux_2_1_32 #(.N(N)) u_alusrc (
        .i_sel (ALUSrc),
        .i_a   (w_rt_data),
        .i_b   (w_imm),
        .o_y   (w_b)
    );

    ALU_32 #(.N(N)) u_alu (
        .i_a        (w_a),
        .i_b        (w_b),
        .i_op       (ALU_OP),
        .o_result   (alu_result),
        .o_carry    (carry_out),
        .o_overflow (overflow),
        .o_slt      (slt)
    );

    assign zero = (alu_result == '0);

    DataMemory #(.N(N), .MEM_WORDS(MEM_WORDS)) u_dmem (
        .clk     (clk),
        .rst_n   (rst),
        .i_addr  (alu_result[AW-1:0]),
        .i_wdata (w_rt_data),
        .i_we    (MemWrite),
        .i_re    (MemRead),
        .o_rdata (w_rdata)
    );

    Mux_2_1_32 #(.N(N)) u_memtoreg (
        .i_sel (MemtoReg),
        .i_a   (alu_result),
        .i_b   (w_rdata),
        .o_y   (wb_data)
    );

    // Register file: reset loads R[i]=i; R0 is never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= N'(i);
        end else if (RegWrite && w_dest != 5'd0) begin
            r_regs[w_dest] <= wb_data;
        end
    end
endmodule

// File: tb/tb_load_store_r_i_instruction.sv
// Bench for load_store_r_i_instruction: vector table plus scoreboard queue,
// with hand sequences for overflow construction and mid-run reset.

module tb_load_store_r_i_instruction;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic [3:0]  ALU_OP;
    logic        RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst;
    logic [31:0] alu_result, wb_data;
    logic        zero, carry_out, overflow, slt;

    always #5 clk = ~clk;

    load_store_r_i_instruction dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .ALU_OP      (ALU_OP),
        .RegWrite    (RegWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrc      (ALUSrc),
        .RegDst      (RegDst),
        .alu_result  (alu_result),
        .wb_data     (wb_data),
        .zero        (zero),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .slt         (slt)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic        rw, mr, mw, m2r, src, dst;
        logic [31:0] alu, wb;
        logic [3:0]  fl;  // {zero, carry, overflow, slt}
    } vec_t;

    vec_t sb[$];
    vec_t tbl[43];
    int   n_chk = 0;
    int   n_fail = 0;
    int   vid = 0;

    function automatic vec_t mk(
        input logic [3:0] op, input logic [4:0] rs, rt, rd,
        input logic [15:0] imm,
        input logic rw, mr, mw, m2r, src, dst,
        input logic [31:0] alu, wb, input logic [3:0] fl);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.imm = imm;
        v.rw = rw; v.mr = mr; v.mw = mw; v.m2r = m2r;
        v.src = src; v.dst = dst;
        v.alu = alu; v.wb = wb; v.fl = fl;
        return v;
    endfunction

    // OR Rr with R0, no writeback: exposes a register value
    function automatic vec_t rd_reg(input logic [4:0] r,
                                    input logic [31:0] val);
        return mk(4'd1, r, 5'd0, 5'd0, 16'd0, 0, 0, 0, 0, 0, 1,
                  val, val, {val == 32'd0, 3'b000});
    endfunction

    // lw-style read of mem[a] with no writeback
    function automatic vec_t rd_mem(input logic [15:0] a,
                                    input logic [31:0] val);
        return mk(4'd2, 5'd0, 5'd0, 5'd0, a, 0, 1, 0, 1, 1, 0,
                  {16'd0, a}, val, 4'b0001);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %h want %h", nm, vid, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        instruction = {6'd0, v.rs, v.rt, v.src ? v.imm : {v.rd, 11'd0}};
        ALU_OP = v.op;
        RegWrite = v.rw; MemRead = v.mr; MemWrite = v.mw;
        MemtoReg = v.m2r; ALUSrc = v.src; RegDst = v.dst;
        sb.push_back(v);
    endtask

    task automatic check_out();
        vec_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty vec%0d: got 0 want 1 entries", vid);
        end else begin
            n_chk--;
            e = sb.pop_front();
            cmp("alu_result", alu_result, e.alu);
            cmp("wb_data", wb_data, e.wb);
            cmp("flags", {28'd0, zero, carry_out, overflow, slt},
                {28'd0, e.fl});
        end
        vid++;
    endtask

    task automatic run(input vec_t v);
        drive(v);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(2, 2, 1, 0, 1, 1, 1, 0, 1, 1, 0, 3, 8, 4'b0000);
        tbl[1]  = rd_reg(1, 8);
        tbl[2]  = mk(2, 2, 3, 0, 2, 1, 1, 0, 1, 1, 0, 4, 8, 4'b0000);
        tbl[3]  = rd_reg(3, 8);
        tbl[4]  = mk(2, 5, 5, 0, 2, 0, 0, 1, 0, 1, 0, 7, 7, 4'b0000);
        tbl[5]  = mk(2, 4, 1, 0, 2, 0, 0, 1, 0, 1, 0, 6, 6, 4'b0000);
        tbl[6]  = rd_mem(16'd7, 5);
        tbl[7]  = rd_mem(16'd6, 8);
        tbl[8]  = rd_mem(16'h0107, 5);
        tbl[9]  = mk(2, 0, 0, 0, 7, 0, 0, 0, 1, 1, 0, 7, 0, 4'b0001);
        tbl[10] = mk(2, 0, 17, 0, 20, 1, 0, 0, 0, 1, 0, 20, 20, 4'b0001);
        tbl[11] = mk(2, 0, 2, 16, 0, 1, 0, 0, 0, 0, 1, 2, 2, 4'b0001);
        tbl[12] = mk(2, 2, 18, 0, 63, 1, 0, 0, 0, 1, 0, 65, 65, 4'b0001);
        tbl[13] = mk(2, 2, 3, 19, 0, 1, 0, 0, 0, 0, 1, 10, 10, 4'b0001);
        tbl[14] = mk(2, 4, 20, 0, 16'hFFFF, 1, 0, 0, 0, 1, 0, 3, 3, 4'b0100);
        tbl[15] = mk(6, 9, 8, 21, 0, 1, 0, 0, 0, 0, 1, 1, 1, 4'b0100);
        tbl[16] = mk(0, 6, 22, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4'b1000);
        tbl[17] = mk(1, 8, 23, 0, 0, 1, 0, 0, 0, 1, 0, 8, 8, 4'b0000);
        tbl[18] = mk(0, 6, 7, 24, 0, 1, 0, 0, 0, 0, 1, 6, 6, 4'b0001);
        tbl[19] = mk(2, 11, 11, 0, 16'hFFF6, 1, 0, 0, 0, 1, 0, 1, 1, 4'b0100);
        tbl[20] = rd_reg(17, 20);
        tbl[21] = rd_reg(16, 2);
        tbl[22] = rd_reg(18, 65);
        tbl[23] = rd_reg(19, 10);
        tbl[24] = rd_reg(20, 3);
        tbl[25] = rd_reg(21, 1);
        tbl[26] = rd_reg(22, 0);
        tbl[27] = rd_reg(23, 8);
        tbl[28] = rd_reg(24, 6);
        tbl[29] = rd_reg(11, 1);
        tbl[30] = mk(6, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0,
                     32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0001);
        tbl[31] = mk(2, 0, 29, 0, 16'hFFFB, 1, 0, 0, 0, 1, 0,
                     32'hFFFFFFFB, 32'hFFFFFFFB, 4'b0000);
        tbl[32] = mk(7, 29, 0, 0, 3, 0, 0, 0, 0, 1, 0, 1, 1, 4'b0001);
        tbl[33] = mk(12, 0, 0, 25, 0, 1, 0, 0, 0, 0, 1,
                     32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000);
        tbl[34] = mk(2, 0, 0, 0, 7, 1, 0, 0, 0, 1, 0, 7, 7, 4'b0001);
        tbl[35] = rd_reg(0, 0);
        tbl[36] = mk(3, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1001);
        tbl[37] = mk(2, 5, 5, 0, 1, 1, 0, 0, 0, 1, 0, 6, 6, 4'b0000);
        tbl[38] = rd_reg(5, 6);
        tbl[39] = mk(2, 0, 12, 0, 9, 1, 1, 1, 1, 1, 0, 9, 8, 4'b0001);
        tbl[40] = rd_mem(16'd9, 12);
        tbl[41] = rd_reg(12, 8);
        tbl[42] = mk(7, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000);

        // Reset state: ADD R2+R3 is visible while reset is held
        rst = 1'b0;
        drive(mk(2, 2, 3, 0, 0, 1, 0, 1, 0, 0, 1, 5, 5, 4'b0001));
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (tbl[i]) run(tbl[i]);

        // Build 0x80000000 in R27 by repeated doubling
        run(mk(2, 0, 27, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 4'b0001));
        for (int k = 1; k < 32; k++)
            run(mk(2, 27, 27, 27, 0, 1, 0, 0, 0, 0, 1,
                   32'd1 << k, 32'd1 << k, {2'b00, k == 31, 1'b0}));
        run(mk(2, 27, 27, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1110));
        run(mk(12, 27, 27, 28, 0, 1, 0, 0, 0, 0, 1,
               32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0000));
        run(mk(2, 28, 0, 0, 1, 0, 0, 0, 0, 1, 0,
               32'h80000000, 32'h80000000, 4'b0010));

        // Reset lands on an in-flight register write and store
        drive(mk(2, 0, 1, 0, 7, 1, 0, 1, 0, 1, 0, 7, 7, 4'b0001));
        rst = 1'b0;
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
        rst = 1'b1;
        run(rd_reg(1, 1));
        run(rd_mem(16'd7, 8));
        run(rd_mem(16'd9, 8));
        run(rd_reg(5, 5));
        run(rd_reg(17, 17));
        run(rd_reg(12, 12));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
